pixel_word_packer: RTL and testbench
====================================

# pixel_word_packer

Upstream feeder for the brightness stage. Accepts a stream of 8-bit grayscale pixels with a valid/ready handshake and packs four consecutive pixels into one 32-bit word: first pixel in [31:24], fourth in [7:0]. The word is presented through a registered valid/ready output whose data port connects directly to the brightness stage's 32-bit input. Sustains one pixel per clock when downstream does not stall.

## Interface
- PAD_PIXEL, 8'h00, value placed in unfilled lanes when a partial word is flushed.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  8  incoming pixel.
- pix_valid  in  1  pix_in valid this cycle.
- pix_last  in  1  pix_in is the last pixel of the frame; qualified by pix_valid.
- pix_ready  out  1  packer accepts pix_in this cycle.
- word_out  out  32  packed word, lane 0 in [31:24].
- word_valid  out  1  word_out holds a complete or flushed word.
- word_last  out  1  word_out contains the frame's last pixel.
- word_fill  out  3  number of real pixels in word_out, 1..4.
- word_ready  in  1  downstream consumes word_out this cycle.

## Operation
- A pixel is accepted when pix_valid && pix_ready. A word is transferred when word_valid && word_ready.
- Assembly register asm[31:0] and lane counter idx[1:0]. States: FILL0..FILL3, equal to idx; reset state FILL0.
- On accept, pix_in is written to lane idx: lane 0 = [31:24], lane 3 = [7:0].
- Completion occurs on an accept in FILL3, or, with flush enabled, on an accept with pix_last in any state.
- On completion, the output register loads the assembled word including the current pixel. Lanes above idx load PAD_PIXEL. word_fill = idx+1. word_last = pix_last. word_valid is set. idx returns to FILL0.
- A non-completing accept advances idx by 1. asm lanes not yet written are don't-care internally but must never appear unpadded on word_out.
- pix_ready = !rst && (!word_valid || word_ready). This applies regardless of idx.
- Simultaneous word transfer and completion: the output register reloads with the new word and word_valid stays 1 with no bubble.
- Transfer without completion: word_valid clears next cycle.
- word_out, word_last and word_fill hold stable while word_valid && !word_ready.
- Arithmetic: idx wraps modulo 4. No other arithmetic; pixel values pass bit-exact.

## Timing
- Reset values: word_out=32'h0, word_valid=0, word_last=0, word_fill=3'd0, idx=0. pix_ready=0 while rst is high and 1 the cycle after release.
- Latency: word_valid rises the cycle after the completing pixel is accepted.
- Throughput: 4 pixels per word, back to back, with word_ready held high.
- Stall: word_ready=0 with word_valid=1 drops pix_ready the same cycle (combinational).
- Reset mid-word or mid-stall: the partial word and the pending output are discarded. No word is emitted for them.
- pix_last on a FILL3 accept is a normal completion with word_last=1 and word_fill=4.

## Configuration
- PACKER_FLUSH_EN defined: pix_last forces completion of a partial word as described, and word_last/word_fill reflect it.
- PACKER_FLUSH_EN undefined: pix_last is ignored, and only FILL3 accepts complete a word. word_last is tied to 0 and word_fill to 3'd4. Frame lengths must then be multiples of 4.

## Test plan
- Reset, then 8 pixels 01..08 streamed with word_ready=1 -> word 32'h01020304 and then 32'h05060708. Each word_valid rises one cycle after its 4th pixel. pix_ready stays 1 throughout.
- Backpressure: word_ready=0 for 5 cycles after the first word -> word_out held at 32'h01020304. pix_ready=0 for those cycles. The next word completes with no pixel lost or duplicated.
- Flush (PACKER_FLUSH_EN): pixels AA, BB, then CC with pix_last, PAD_PIXEL=8'hEE -> word 32'hAABBCCEE, word_fill=3, word_last=1. The next frame starts in lane 0.
- No flush (macro undefined): same stimulus -> no word emitted until a 4th pixel DD arrives. Word is 32'hAABBCCDD with word_last=0.
- Reset asserted after 2 pixels -> no word emitted. The next 4 pixels form a clean word starting at [31:24].
- Simultaneous: word_ready=1 on the same cycle the next word completes -> word_valid continuously high and the new data appears the next cycle.

Source files
------------

// File: rtl/pixel_word_packer.sv
// Packs four 8-bit pixels into one 32-bit word (first pixel in [31:24]) behind a registered valid/ready output.
// Optional feature: define PACKER_FLUSH_EN to let pix_last flush a partial, padded word.
module pixel_word_packer #(
    parameter logic [7:0] PAD_PIXEL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        word_last,
    output logic [2:0]  word_fill,
    input  logic        word_ready
);

`ifdef PACKER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] asm_word;
    logic [31:0] next_word;
    logic [31:0] word_q;
    logic        valid_q;
    logic        last_q;
    logic [2:0]  fill_q;
    logic        accept;
    logic        complete;

    assign pix_ready = !rst && (!valid_q || word_ready);
    assign accept    = pix_valid && pix_ready;
    assign complete  = accept && ((state == FILL3) || (FLUSH_EN && pix_last));

    // Lanes above the current one are padded so a flushed word never exposes stale pixels.
    always_comb begin
        next_word = asm_word;
        case (state)
            FILL0:   next_word = {pix_in, PAD_PIXEL, PAD_PIXEL, PAD_PIXEL};
            FILL1:   next_word = {asm_word[31:24], pix_in, PAD_PIXEL, PAD_PIXEL};
            FILL2:   next_word = {asm_word[31:16], pix_in, PAD_PIXEL};
            FILL3:   next_word = {asm_word[31:8], pix_in};
            default: next_word = asm_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL0;
            asm_word <= 32'h0;
            word_q   <= 32'h0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            fill_q   <= 3'd0;
        end else begin
            if (valid_q && word_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                asm_word <= next_word;
                if (complete) begin
                    word_q  <= next_word;
                    valid_q <= 1'b1;
                    last_q  <= FLUSH_EN && pix_last;
                    fill_q  <= {1'b0, state} + 3'd1;
                    state   <= FILL0;
                end else begin
                    state <= state_t'(state + 2'd1);
                end
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign word_last  = FLUSH_EN ? last_q : 1'b0;
    assign word_fill  = FLUSH_EN ? fill_q : 3'd4;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench for pixel_word_packer; expected words are queued as pixels are driven.
// Flush-specific scenarios follow PACKER_FLUSH_EN exactly as the design does.
module tb_pixel_word_packer;

`ifdef PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif
    localparam logic [7:0] PAD = 8'hEE;

    typedef struct {
        logic [31:0] w;
        logic        l;
        logic [2:0]  f;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pix_in = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_last = 1'b0;
    logic        pix_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_last;
    logic [2:0]  word_fill;
    logic        word_ready = 1'b0;

    int total = 0;
    int bad = 0;

    word_t exp_q[$];
    word_t got_q[$];

    int          m_idx = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_buf = 32'h0;

    pixel_word_packer #(.PAD_PIXEL(PAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_ready (pix_ready),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_last (word_last),
        .word_fill (word_fill),
        .word_ready(word_ready)
    );

    always #5 clk = ~clk;

    // Record every word the DUT hands over, sampled mid-cycle ahead of the transferring edge.
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            got_q.push_back('{w: word_out, l: word_last, f: word_fill});
        end
    end

    task automatic applyStimulus(input logic [7:0] p, input logic v, input logic l, input logic wr,
                                 output logic exp_rdy, output logic obs_rdy);
        logic  acc;
        logic  cmp;
        word_t e;
        pix_in = p;
        pix_valid = v;
        pix_last = l;
        word_ready = wr;
        #1;
        obs_rdy = pix_ready;
        exp_rdy = !(m_valid && !wr);
        acc = v && exp_rdy;
        cmp = acc && ((m_idx == 3) || (FLUSH && l));
        if (acc) begin
            m_buf[(3 - m_idx) * 8 +: 8] = p;
            if (cmp) begin
                e.w = m_buf;
                for (int k = m_idx + 1; k < 4; k++) e.w[(3 - k) * 8 +: 8] = PAD;
                e.l = FLUSH ? l : 1'b0;
                e.f = FLUSH ? 3'(m_idx + 1) : 3'd4;
                exp_q.push_back(e);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (cmp) m_valid = 1'b1;
        else if (m_valid && wr) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        m_idx = 0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (word_out !== 32'h0) begin bad++; $display("[TB] FAIL reset word_out got=%h want=%h", word_out, 32'h0); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset word_valid got=%b want=0", word_valid); end
        total++; if (word_last !== 1'b0) begin bad++; $display("[TB] FAIL reset word_last got=%b want=0", word_last); end
        total++; if (word_fill !== (FLUSH ? 3'd0 : 3'd4)) begin bad++; $display("[TB] FAIL reset word_fill got=%0d want=%0d", word_fill, FLUSH ? 0 : 4); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset pix_ready got=%b want=0", pix_ready); end
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL release pix_ready got=%b want=1", pix_ready); end
    endtask

    task automatic test_stream();
        logic er, orr;
        word_t e, g;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(i + 1), 1'b1, 1'b0, 1'b1, er, orr);
            total++; if (orr !== er) begin bad++; $display("[TB] FAIL stream pix_ready[%0d] got=%b want=%b", i, orr, er); end
            if (i == 2 || i == 4) begin
                total++; if (word_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream early valid[%0d] got=%b want=0", i, word_valid); end
            end
            if (i == 3 || i == 7) begin
                total++; if (word_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream valid[%0d] got=%b want=1", i, word_valid); end
            end
        end
        repeat (3) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, er, orr);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL stream word missing got=none want=%h", e.w); end
            else begin
                g = got_q.pop_front();
                if (g.w !== e.w || g.l !== e.l || g.f !== e.f) begin bad++; $display("[TB] FAIL stream word got=%h/%b/%0d want=%h/%b/%0d", g.w, g.l, g.f, e.w, e.l, e.f); end
            end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL stream extra words got=%0d want=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_backpressure();
        logic er, orr;
        logic [7:0] p;
        word_t e, g;
        for (int i = 0; i < 4; i++) applyStimulus(8'h21 + 8'(i), 1'b1, 1'b0, 1'b1, er, orr);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h25, 1'b1, 1'b0, 1'b0, er, orr);
            total++; if (orr !== 1'b0) begin bad++; $display("[TB] FAIL stall pix_ready[%0d] got=%b want=0", i, orr); end
            total++; if (word_out !== 32'h21222324 || word_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall hold[%0d] got=%h/%b want=21222324/1", i, word_out, word_valid); end
        end
        p = 8'h25;
        for (int c = 0; c < 10 && p <= 8'h28; c++) begin
            applyStimulus(p, 1'b1, 1'b0, 1'b1, er, orr);
            if (er) p++;
        end
        repeat (3) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, er, orr);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL backpressure word missing got=none want=%h", e.w); end
            else begin
                g = got_q.pop_front();
                if (g.w !== e.w || g.l !== e.l || g.f !== e.f) begin bad++; $display("[TB] FAIL backpressure word got=%h/%b/%0d want=%h/%b/%0d", g.w, g.l, g.f, e.w, e.l, e.f); end
            end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL backpressure extra words got=%0d want=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_flush();
        logic er, orr;
        word_t e, g;
        applyStimulus(8'hAA, 1'b1, 1'b0, 1'b1, er, orr);
        applyStimulus(8'hBB, 1'b1, 1'b0, 1'b1, er, orr);
        applyStimulus(8'hCC, 1'b1, 1'b1, 1'b1, er, orr);
        if (FLUSH) begin
            total++; if (word_valid !== 1'b1 || word_out !== 32'hAABBCCEE || word_fill !== 3'd3 || word_last !== 1'b1) begin
                bad++; $display("[TB] FAIL flush word got=%h/%b/%0d/%b want=aabbccee/1/3/1", word_out, word_valid, word_fill, word_last); end
            for (int i = 0; i < 4; i++) applyStimulus(8'(i + 1), 1'b1, (i == 3), 1'b1, er, orr);
        end else begin
            repeat (2) begin
                applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, er, orr);
                total++; if (word_valid !== 1'b0) begin bad++; $display("[TB] FAIL noflush early word got=%b want=0", word_valid); end
            end
            applyStimulus(8'hDD, 1'b1, 1'b0, 1'b1, er, orr);
            total++; if (word_out !== 32'hAABBCCDD || word_last !== 1'b0) begin bad++; $display("[TB] FAIL noflush word got=%h/%b want=aabbccdd/0", word_out, word_last); end
        end
        repeat (3) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, er, orr);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL flush word missing got=none want=%h", e.w); end
            else begin
                g = got_q.pop_front();
                if (g.w !== e.w || g.l !== e.l || g.f !== e.f) begin bad++; $display("[TB] FAIL flush scoreboard got=%h/%b/%0d want=%h/%b/%0d", g.w, g.l, g.f, e.w, e.l, e.f); end
            end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL flush extra words got=%0d want=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_reset_mid();
        logic er, orr;
        word_t e, g;
        applyStimulus(8'h31, 1'b1, 1'b0, 1'b1, er, orr);
        applyStimulus(8'h32, 1'b1, 1'b0, 1'b1, er, orr);
        for (int r = 0; r < 2; r++) begin
            rst = 1'b1;
            pix_valid = 1'b0;
            word_ready = 1'b0;
            @(posedge clk);
            #1;
            total++; if (pix_ready !== 1'b0) begin bad++; $display("[TB] FAIL midreset pix_ready[%0d] got=%b want=0", r, pix_ready); end
            rst = 1'b0;
            modelReset();
            total++; if (word_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset word_valid[%0d] got=%b want=0", r, word_valid); end
            if (r == 0) begin
                for (int i = 0; i < 4; i++) applyStimulus(8'h41 + 8'(i), 1'b1, 1'b0, 1'b1, er, orr);
                repeat (2) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, er, orr);
            end
        end
        for (int i = 0; i < 4; i++) applyStimulus(8'h51 + 8'(i), 1'b1, 1'b0, 1'b1, er, orr);
        total++; if (word_out !== 32'h51525354) begin bad++; $display("[TB] FAIL midreset clean word got=%h want=51525354", word_out); end
        repeat (3) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, er, orr);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL midreset word missing got=none want=%h", e.w); end
            else begin
                g = got_q.pop_front();
                if (g.w !== e.w || g.l !== e.l || g.f !== e.f) begin bad++; $display("[TB] FAIL midreset scoreboard got=%h/%b/%0d want=%h/%b/%0d", g.w, g.l, g.f, e.w, e.l, e.f); end
            end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL midreset extra words got=%0d want=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_back_to_back();
        logic er, orr;
        word_t e, g;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'h61 + 8'(i), 1'b1, 1'b0, 1'b1, er, orr);
            total++; if (orr !== 1'b1) begin bad++; $display("[TB] FAIL b2b pix_ready[%0d] got=%b want=1", i, orr); end
            total++; if (word_valid !== ((i % 4) == 3)) begin bad++; $display("[TB] FAIL b2b valid[%0d] got=%b want=%b", i, word_valid, (i % 4) == 3); end
        end
        if (FLUSH) begin
            for (int i = 0; i < 3; i++) begin
                applyStimulus(8'h71 + 8'(i), 1'b1, 1'b1, 1'b1, er, orr);
                total++; if (word_valid !== 1'b1 || word_out !== {8'h71 + 8'(i), PAD, PAD, PAD}) begin
                    bad++; $display("[TB] FAIL simultaneous[%0d] got=%h/%b want=%h/1", i, word_out, word_valid, {8'h71 + 8'(i), PAD, PAD, PAD}); end
            end
        end
        repeat (3) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, er, orr);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL b2b word missing got=none want=%h", e.w); end
            else begin
                g = got_q.pop_front();
                if (g.w !== e.w || g.l !== e.l || g.f !== e.f) begin bad++; $display("[TB] FAIL b2b scoreboard got=%h/%b/%0d want=%h/%b/%0d", g.w, g.l, g.f, e.w, e.l, e.f); end
            end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL b2b extra words got=%0d want=0", got_q.size()); got_q.delete(); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
